// File: rtl/m_ext_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide coprocessor on the PicoRV32 PCPI port.
// Shift-add multiplier (MUL_STEP bits/cycle) and restoring divider (1 bit/cycle).
module m_ext_muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int MUL_STEP      = 1,
    parameter int EARLY_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rd_q, rd_d;

    logic [2:0]        f3;
    logic              is_muldiv, s1, s2, sgn1, sgn2, special;
    logic [XLEN-1:0]   mag1, mag2, special_res;
    logic [2*XLEN-1:0] mul_sum, div_next;
    logic [XLEN:0]     trial;
    logic              unused_insn;

    assign f3          = pcpi_insn[14:12];
    assign is_muldiv   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign s1   = pcpi_rs1[XLEN-1];
    assign s2   = pcpi_rs2[XLEN-1];
    assign sgn1 = (f3 == 3'b001) || (f3 == 3'b010) || (f3[2] && !f3[0]);
    assign sgn2 = (f3 == 3'b001) || (f3[2] && !f3[0]);
    assign mag1 = (sgn1 && s1) ? -pcpi_rs1 : pcpi_rs1;
    assign mag2 = (sgn2 && s2) ? -pcpi_rs2 : pcpi_rs2;

    assign special = f3[2] && ((pcpi_rs2 == '0) ||
                     (!f3[0] && (pcpi_rs1 == MIN_NEG) && (pcpi_rs2 == '1)));
    assign special_res = (pcpi_rs2 == '0) ? (f3[1] ? pcpi_rs1 : '1)
                                          : (f3[1] ? '0 : pcpi_rs1);

    function automatic logic [XLEN-1:0] finish(input logic [2:0] op, input logic neg,
                                               input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = neg ? -acc : acc;
        q = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 return p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return p[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return q;
            default:                return r;
        endcase
    endfunction

    always_comb begin
        mul_sum = acc_q;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (opb_q[i]) mul_sum = mul_sum + (opa_q << i);
        end
        // acc holds {remainder, dividend/quotient}; quotient bits shift in from the right
        trial = acc_q[2*XLEN-1:XLEN-1];
        if (trial >= {1'b0, opb_q}) begin
            div_next = {trial[XLEN-1:0] - opb_q, acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (pcpi_valid && is_muldiv) begin
                    op_d             = f3;
                    opa_d            = '0;
                    opa_d[XLEN-1:0]  = mag1;
                    opb_d            = mag2;
                    acc_d            = '0;
                    if (f3[2]) acc_d[XLEN-1:0] = mag1;
                    cnt_d            = f3[2] ? CW'(XLEN) : CW'(XLEN / MUL_STEP);
                    // Zero divisor must keep the all-ones quotient unsigned
                    if (f3 == 3'b100)      neg_d = (s1 ^ s2) && (pcpi_rs2 != '0);
                    else if (f3 == 3'b110) neg_d = s1;
                    else                   neg_d = (sgn1 && s1) ^ (sgn2 && s2);
                    if ((EARLY_SPECIAL != 0) && special) begin
                        state_d = S_DONE;
                        rd_d    = special_res;
                    end else begin
                        state_d = f3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (!pcpi_valid) begin
                    state_d = S_IDLE;
                end else begin
                    if (state_q == S_MUL) begin
                        acc_d = mul_sum;
                        opa_d = opa_q << MUL_STEP;
                        opb_d = opb_q >> MUL_STEP;
                    end else begin
                        acc_d = div_next;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        rd_d    = finish(op_q, neg_q, acc_d);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
        end
    end

    assign pcpi_wait  = (state_q == S_MUL) || (state_q == S_DIV);
    assign pcpi_ready = (state_q == S_DONE);
    assign pcpi_wr    = (state_q == S_DONE);
    assign pcpi_rd    = rd_q;
endmodule

// File: tb/tb_m_ext_muldiv_unit.sv
// Scoreboard bench for m_ext_muldiv_unit: three parameterisations driven with
// directed vectors; a negedge monitor checks every ready pulse against the queue.
module tb_m_ext_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  valid;
    logic [31:0] insn;
    logic [63:0] rs1, rs2;
    logic [2:0]  wt, rdy, wrv;
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;
    logic [63:0] rdv [3];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          d;
        string       name;
        logic [63:0] rd;
        int          cyc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m_ext_muldiv_unit #(.XLEN(32), .MUL_STEP(1), .EARLY_SPECIAL(1)) dut0 (
        .clk(clk), .rst(rst), .pcpi_valid(valid[0]), .pcpi_insn(insn),
        .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(wrv[0]),
        .pcpi_rd(rd0), .pcpi_wait(wt[0]), .pcpi_ready(rdy[0]));

    m_ext_muldiv_unit #(.XLEN(32), .MUL_STEP(2), .EARLY_SPECIAL(0)) dut1 (
        .clk(clk), .rst(rst), .pcpi_valid(valid[1]), .pcpi_insn(insn),
        .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(wrv[1]),
        .pcpi_rd(rd1), .pcpi_wait(wt[1]), .pcpi_ready(rdy[1]));

    m_ext_muldiv_unit #(.XLEN(64), .MUL_STEP(4), .EARLY_SPECIAL(1)) dut2 (
        .clk(clk), .rst(rst), .pcpi_valid(valid[2]), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wrv[2]),
        .pcpi_rd(rd2), .pcpi_wait(wt[2]), .pcpi_ready(rdy[2]));

    assign rdv[0] = {32'b0, rd0};
    assign rdv[1] = {32'b0, rd1};
    assign rdv[2] = rd2;

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rdy[d]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready dut%0d: rd=%h at cycle %0d, no request outstanding",
                             d, rdv[d], cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.d != d || rdv[d] !== e.rd || cyc != e.cyc || wrv[d] !== 1'b1) begin
                        errors++;
                        $display("FAIL %s dut%0d: got rd=%h wr=%b cycle=%0d, expected dut%0d rd=%h wr=1 cycle=%0d",
                                 e.name, d, rdv[d], wrv[d], cyc, e.d, e.rd, e.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input string name, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_rd, input int lat);
        int waits;
        bit got;
        @(negedge clk);
        insn     = mk(f3);
        rs1      = a;
        rs2      = b;
        valid[d] = 1'b1;
        q.push_back('{d: d, name: name, rd: exp_rd, cyc: cyc + lat});
        waits = 0;
        got   = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            rs1 = ~a;
            rs2 = ~b ^ 64'h5;
            if (wt[d]) waits++;
            if (rdy[d]) got = 1'b1;
        end
        valid[d] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout dut%0d: no ready within 200 cycles", name, d);
        end else if (waits != lat - 1) begin
            errors++;
            $display("FAIL %s_wait dut%0d: wait high %0d cycles, expected %0d", name, d, waits, lat - 1);
        end
    endtask

    initial begin
        int bad;
        rst   = 1'b1;
        valid = '0;
        insn  = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wt, rdy, wrv} !== '0 || rdv[0] !== '0 || rdv[1] !== '0 || rdv[2] !== '0) begin
            errors++;
            $display("FAIL reset_state: wait=%b ready=%b wr=%b rd0=%h rd2=%h, expected all 0",
                     wt, rdy, wrv, rdv[0], rdv[2]);
        end
        rst = 1'b0;

        issue(0, "mul",    3'b000, 64'd7,        64'hFFFFFFFD, 64'hFFFFFFEB, 33);
        issue(0, "mulh",   3'b001, 64'h80000000, 64'h80000000, 64'h40000000, 33);
        issue(0, "mulhsu", 3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33);
        issue(0, "mulhu",  3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);
        issue(0, "div",    3'b100, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, 33);
        issue(0, "rem",    3'b110, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFF, 33);
        issue(0, "divu",   3'b101, 64'd100,      64'd7,        64'd14,       33);
        issue(0, "remu",   3'b111, 64'd100,      64'd7,        64'd2,        33);
        issue(0, "divu_z", 3'b101, 64'd5,        64'd0,        64'hFFFFFFFF, 1);
        issue(0, "remu_z", 3'b111, 64'd5,        64'd0,        64'd5,        1);
        issue(0, "div_ov", 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
        issue(0, "rem_ov", 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'd0,        1);
        issue(0, "div_nz", 3'b100, 64'hFFFFFFFB, 64'd0,        64'hFFFFFFFF, 1);
        issue(0, "rem_nz", 3'b110, 64'hFFFFFFFB, 64'd0,        64'hFFFFFFFB, 1);

        // Non-M custom opcode must never be claimed
        @(negedge clk);
        insn     = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
        valid[0] = 1'b1;
        bad      = 0;
        repeat (20) begin
            @(negedge clk);
            if (wt[0] || rdy[0] || wrv[0]) bad++;
        end
        valid[0] = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL non_m_claim: outputs active in %0d of 20 cycles, expected 0", bad);
        end

        // Abort: drop valid in the 10th busy cycle of a DIV
        @(negedge clk);
        insn     = mk(3'b100);
        rs1      = 64'd100;
        rs2      = 64'd7;
        valid[0] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (wt[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: wait=%b at T+10, expected 1", wt[0]);
        end
        valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (wt[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: wait=%b ready=%b at T+11, expected 0 0", wt[0], rdy[0]);
        end
        repeat (40) @(negedge clk);
        issue(0, "mul_after_abort", 3'b000, 64'd3, 64'd4, 64'd12, 33);

        // Reset in the middle of a MUL
        @(negedge clk);
        insn     = mk(3'b000);
        rs1      = 64'd3;
        rs2      = 64'd5;
        valid[0] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wt[0] !== 1'b0 || rdy[0] !== 1'b0 || wrv[0] !== 1'b0 || rdv[0] !== '0) begin
            errors++;
            $display("FAIL mid_reset: wait=%b ready=%b wr=%b rd=%h, expected all 0",
                     wt[0], rdy[0], wrv[0], rdv[0]);
        end
        valid[0] = 1'b0;
        rst      = 1'b0;
        repeat (40) @(negedge clk);

        issue(1, "mul_s2",    3'b000, 64'd7,        64'hFFFFFFFD, 64'hFFFFFFEB, 17);
        issue(1, "mulhu_s2",  3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 17);
        issue(1, "divu_z_l",  3'b101, 64'd5,        64'd0,        64'hFFFFFFFF, 33);
        issue(1, "remu_z_l",  3'b111, 64'd5,        64'd0,        64'd5,        33);
        issue(1, "div_ov_l",  3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33);
        issue(1, "rem_ov_l",  3'b110, 64'h80000000, 64'hFFFFFFFF, 64'd0,        33);
        issue(1, "div_nz_l",  3'b100, 64'hFFFFFFFB, 64'd0,        64'hFFFFFFFF, 33);
        issue(1, "rem_nz_l",  3'b110, 64'hFFFFFFFB, 64'd0,        64'hFFFFFFFB, 33);

        issue(2, "mulhu64", 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFE, 17);
        issue(2, "mul64",   3'b000, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 17);
        issue(2, "mulh64",  3'b001, 64'h8000000000000000, 64'h8000000000000000,
              64'h4000000000000000, 17);
        issue(2, "div64",   3'b100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65);
        issue(2, "remu64",  3'b111, 64'd100, 64'd7, 64'd2, 65);
        issue(2, "div64_ov", 3'b100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
              64'h8000000000000000, 1);

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: %0d expected responses never seen, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
